// File: rtl/ebi_uart_pkg.sv
// ebi_uart_pkg: shared constants and helpers for the EBI UART register hub.
//   - register offsets inside a channel page and inside the global page
//   - FSM state encodings (plain localparams, legacy-tool friendly)
//   - clog2 for parameter-derived widths
//   - lane_merge for byte-lane masked register updates
package ebi_uart_pkg;

  // Per-channel page, selected by ebi_addr[1:0]
  localparam logic [1:0] REG_CR  = 2'd0;
  localparam logic [1:0] REG_SR  = 2'd1;
  localparam logic [1:0] REG_TDR = 2'd2;
  localparam logic [1:0] REG_RDR = 2'd3;

  // Global page (channel index == NUM_CH)
  localparam logic [1:0] G_IRQ_STATUS = 2'd0;
  localparam logic [1:0] G_IRQ_MASK   = 2'd1;
  localparam logic [1:0] G_VERSION    = 2'd2;
  localparam logic [1:0] G_BUS_ERR    = 2'd3;

  // Bus FSM states
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE     = 2'd0;
  localparam fsm_state_t ST_RD       = 2'd1;
  localparam fsm_state_t ST_WR       = 2'd2;
  localparam fsm_state_t ST_WAIT_END = 2'd3;

  // Ceiling log2, never less than 1 so derived vectors stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Replace only the bytes whose lane bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      if (lanes[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ebi_sync_edge.sv
// ebi_sync_edge: W-bit multi-stage synchroniser with edge detection.
// Ports:
//   clk, rst  - system clock, async active-high reset (stages load RST_VAL)
//   d_i       - asynchronous inputs
//   q_o       - synchronised level (STAGES clocks of latency)
//   rise_o    - one-cycle pulse when q_o goes 0->1
//   fall_o    - one-cycle pulse when q_o goes 1->0
module ebi_sync_edge #(
  parameter int           W       = 1,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    stage_d[0] = d_i;
    for (int s = 1; s < STAGES; s++) stage_d[s] = stage_q[s-1];
    prev_d = stage_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= stage_d[s];
      prev_q <= prev_d;
    end
  end

  assign q_o    = stage_q[STAGES-1];
  assign rise_o = stage_q[STAGES-1] & ~prev_q;
  assign fall_o = ~stage_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ebi_uart_hub.sv
// ebi_uart_hub: EBI-slave register hub for NUM_CH UART channels.
// Decodes ch = ebi_addr[CH_W+1:2], reg = ebi_addr[1:0]; ch == NUM_CH is the
// global page (IRQ status/mask, version, bus error); higher ch is a hole.
// Optional build macro: BUS_TIMEOUT_EN (bus-cycle watchdog + BUS_ERR[0]).
// Ports:
//   clk, rst                 - clock, async active-high reset
//   cs_n, oe_n, we_n, rd_wr  - raw EBI strobes (asynchronous)
//   ebi_addr, ebi_data_i     - EBI address / write data
//   ebi_data_o, ebi_data_oe  - registered read data and pad drive enable
//   cr_o, tdr_o              - per-channel CR/TDR, ch i at [32i+31:32i]
//   sr_i, rdr_i              - per-channel status / receive data
//   tx_write_o, rx_read_o, sr_read_o - one-cycle access strobes per channel
//   int_i, irq_o             - channel interrupt levels, masked aggregate
//   dbg_state_o              - current bus FSM state
//
// Bus handshake: all decisions use the synchronised strobes. A read runs
// while cs_n and oe_n are low with rd_wr high; data and oe are presented one
// cycle after entry and held until either strobe rises. A write runs while
// cs_n is low, rd_wr low and any we_n low; it commits on the rise of all
// we_n, and is dropped if cs_n rises first.
module ebi_uart_hub
  import ebi_uart_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  oe_n,
  input  logic [3:0]            we_n,
  input  logic                  rd_wr,
  input  logic [23:0]           ebi_addr,
  input  logic [31:0]           ebi_data_i,
  output logic [31:0]           ebi_data_o,
  output logic                  ebi_data_oe,
  output logic [32*NUM_CH-1:0]  cr_o,
  output logic [32*NUM_CH-1:0]  tdr_o,
  input  logic [32*NUM_CH-1:0]  sr_i,
  input  logic [32*NUM_CH-1:0]  rdr_i,
  output logic [NUM_CH-1:0]     tx_write_o,
  output logic [NUM_CH-1:0]     rx_read_o,
  output logic [NUM_CH-1:0]     sr_read_o,
  input  logic [NUM_CH-1:0]     int_i,
  output logic                  irq_o,
  output logic [1:0]            dbg_state_o
);

  localparam int CH_W = clog2(NUM_CH + 1);
  localparam int AW   = CH_W + 2;

  // ---------------- strobe synchronisation ----------------
  logic [6:0] strobe_sync;
  logic [6:0] strobe_rise_unused;
  logic [6:0] strobe_fall_unused;
  logic       cs_s, oe_s, rd_wr_s;
  logic [3:0] we_s;

  ebi_sync_edge #(
    .W       (7),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (7'h7F)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({rd_wr, we_n, oe_n, cs_n}),
    .q_o    (strobe_sync),
    .rise_o (strobe_rise_unused),
    .fall_o (strobe_fall_unused)
  );

  assign {rd_wr_s, we_s, oe_s, cs_s} = strobe_sync;

  // Address bits above the channel field are not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ebi_addr[23:AW];

  // ---------------- state ----------------
  fsm_state_t           state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           lanes_q, lanes_d;
  logic                 rd_first_q, rd_first_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 oe_q, oe_d;
  logic [32*NUM_CH-1:0] cr_q, cr_d;
  logic [32*NUM_CH-1:0] tdr_q, tdr_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic                 bus_err_q, bus_err_d;
  logic [NUM_CH-1:0]    tx_q, tx_d;
  logic [NUM_CH-1:0]    rx_q, rx_d;
  logic [NUM_CH-1:0]    srr_q, srr_d;
  logic                 irq_q, irq_d;
  logic                 timeout_hit;

  // ---------------- optional watchdog ----------------
`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent in RD/WR; cleared whenever the FSM is elsewhere,
  // so every bus cycle starts at zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_RD || state_q == ST_WR) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // ---------------- decode / read mux ----------------
  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        reg_sel;
  logic              is_global;
  logic [31:0]       rd_data;
  logic [NUM_CH-1:0] rx_hit, sr_hit;

  assign ch_idx    = addr_q[AW-1:2];
  assign reg_sel   = addr_q[1:0];
  assign is_global = (ch_idx == CH_W'(NUM_CH));

  always_comb begin
    rd_data = '0;
    rx_hit  = '0;
    sr_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) begin
        case (reg_sel)
          REG_CR:  rd_data = cr_q[32*i +: 32];
          REG_SR:  begin rd_data = sr_i[32*i +: 32];  sr_hit[i] = 1'b1; end
          REG_TDR: rd_data = tdr_q[32*i +: 32];
          default: begin rd_data = rdr_i[32*i +: 32]; rx_hit[i] = 1'b1; end
        endcase
      end
    end
    if (is_global) begin
      case (reg_sel)
        G_IRQ_STATUS: rd_data = 32'(int_i);
        G_IRQ_MASK:   rd_data = 32'(mask_q);
        G_VERSION:    rd_data = VERSION;
        default:      rd_data = {31'b0, bus_err_q};
      endcase
    end
  end

  // ---------------- bus FSM ----------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lanes_d    = lanes_q;
    rd_first_d = 1'b0;
    rdata_d    = rdata_q;
    oe_d       = oe_q;
    cr_d       = cr_q;
    tdr_d      = tdr_q;
    mask_d     = mask_q;
    bus_err_d  = bus_err_q;
    tx_d       = '0;
    rx_d       = '0;
    srr_d      = '0;
    irq_d      = |(int_i & mask_q);

    case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (!cs_s) begin
          // rd_wr alone picks the direction when both look active.
          if (rd_wr_s) begin
            if (!oe_s) begin
              state_d    = ST_RD;
              addr_d     = ebi_addr[AW-1:0];
              rd_first_d = 1'b1;
            end
          end else if (we_s != 4'hF) begin
            state_d = ST_WR;
            addr_d  = ebi_addr[AW-1:0];
            wdata_d = ebi_data_i;
            lanes_d = ~we_s;
          end
        end
      end

      ST_RD: begin
        if (cs_s || oe_s) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d   = ST_WAIT_END;
          oe_d      = 1'b0;
          bus_err_d = 1'b1;
        end else if (rd_first_q) begin
          // Side-effect strobes fire only on this first data cycle.
          rdata_d = rd_data;
          oe_d    = 1'b1;
          rx_d    = rx_hit;
          srr_d   = sr_hit;
        end
      end

      ST_WR: begin
        if (we_s == 4'hF) begin
          state_d = ST_IDLE;
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
              if (reg_sel == REG_CR)
                cr_d[32*i +: 32] = lane_merge(cr_q[32*i +: 32], wdata_q, lanes_q);
              if (reg_sel == REG_TDR) begin
                tdr_d[32*i +: 32] = lane_merge(tdr_q[32*i +: 32], wdata_q, lanes_q);
                tx_d[i]           = 1'b1;
              end
            end
          end
          if (is_global) begin
            // Mask and error flag both live in byte lane 0.
            if (reg_sel == G_IRQ_MASK && lanes_q[0]) mask_d = wdata_q[NUM_CH-1:0];
            if (reg_sel == G_BUS_ERR && lanes_q[0] && wdata_q[0]) bus_err_d = 1'b0;
          end
        end else if (cs_s) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d   = ST_WAIT_END;
          bus_err_d = 1'b1;
        end else begin
          wdata_d = ebi_data_i;
          lanes_d = ~we_s;
        end
      end

      ST_WAIT_END: begin
        oe_d = 1'b0;
        if (cs_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lanes_q    <= '0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
      cr_q       <= '0;
      tdr_q      <= '0;
      mask_q     <= '0;
      bus_err_q  <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      srr_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lanes_q    <= lanes_d;
      rd_first_q <= rd_first_d;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
      cr_q       <= cr_d;
      tdr_q      <= tdr_d;
      mask_q     <= mask_d;
      bus_err_q  <= bus_err_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      srr_q      <= srr_d;
      irq_q      <= irq_d;
    end
  end

  assign ebi_data_o  = rdata_q;
  assign ebi_data_oe = oe_q;
  assign cr_o        = cr_q;
  assign tdr_o       = tdr_q;
  assign tx_write_o  = tx_q;
  assign rx_read_o   = rx_q;
  assign sr_read_o   = srr_q;
  assign irq_o       = irq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ebi_uart_hub.sv
// tb_ebi_uart_hub: directed self-checking bench for ebi_uart_hub (NUM_CH=4).
// With BUS_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYC=16 and the
// watchdog sequence is exercised as well.
module tb_ebi_uart_hub;

  localparam int NUM_CH = 4;
`ifdef BUS_TIMEOUT_EN
  localparam int TO_CYC  = 16;
  localparam int RD_HOLD = 8;
`else
  localparam int TO_CYC  = 255;
  localparam int RD_HOLD = 20;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                 cs_n, oe_n, rd_wr;
  logic [3:0]           we_n;
  logic [23:0]          ebi_addr;
  logic [31:0]          ebi_data_i, ebi_data_o;
  logic                 ebi_data_oe;
  logic [32*NUM_CH-1:0] cr_o, tdr_o, sr_i, rdr_i;
  logic [NUM_CH-1:0]    tx_write_o, rx_read_o, sr_read_o, int_i;
  logic                 irq_o;
  logic [1:0]           dbg_state_o;

  ebi_uart_hub #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TO_CYC),
    .VERSION     (32'h0002_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cs_n        (cs_n),
    .oe_n        (oe_n),
    .we_n        (we_n),
    .rd_wr       (rd_wr),
    .ebi_addr    (ebi_addr),
    .ebi_data_i  (ebi_data_i),
    .ebi_data_o  (ebi_data_o),
    .ebi_data_oe (ebi_data_oe),
    .cr_o        (cr_o),
    .tdr_o       (tdr_o),
    .sr_i        (sr_i),
    .rdr_i       (rdr_i),
    .tx_write_o  (tx_write_o),
    .rx_read_o   (rx_read_o),
    .sr_read_o   (sr_read_o),
    .int_i       (int_i),
    .irq_o       (irq_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  int tx_cnt [NUM_CH] = '{default: 0};
  int rx_cnt [NUM_CH] = '{default: 0};
  int sr_cnt [NUM_CH] = '{default: 0};
  int tx_b   [NUM_CH];
  int rx_b   [NUM_CH];
  int sr_b   [NUM_CH];

  // Strobes are one cycle wide, so sampling once per cycle counts pulses.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (tx_write_o[i] === 1'b1) tx_cnt[i]++;
      if (rx_read_o[i]  === 1'b1) rx_cnt[i]++;
      if (sr_read_o[i]  === 1'b1) sr_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < NUM_CH; i++) begin
      tx_b[i] = tx_cnt[i];
      rx_b[i] = rx_cnt[i];
      sr_b[i] = sr_cnt[i];
    end
  endtask

  // Pulse-count deltas since snap(), one nibble per channel (ch0 lowest).
  function automatic logic [15:0] tx_delta();
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++) d[4*i +: 4] = 4'(tx_cnt[i] - tx_b[i]);
    return d;
  endfunction

  function automatic logic [15:0] rx_delta();
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++) d[4*i +: 4] = 4'(rx_cnt[i] - rx_b[i]);
    return d;
  endfunction

  function automatic logic [15:0] sr_delta();
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++) d[4*i +: 4] = 4'(sr_cnt[i] - sr_b[i]);
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    cs_n = 1'b1; oe_n = 1'b1; we_n = 4'hF; rd_wr = 1'b1;
  endtask

  task automatic ebi_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    ebi_addr = a; ebi_data_i = d; rd_wr = 1'b0; cs_n = 1'b0; we_n = we;
    cyc(6);
    we_n = 4'hF;
    cyc(4);
    cs_n = 1'b1; rd_wr = 1'b1;
    cyc(4);
  endtask

  task automatic ebi_read(input logic [23:0] a, input int hold,
                          output logic [31:0] d, output logic oe);
    @(negedge clk);
    ebi_addr = a; rd_wr = 1'b1; cs_n = 1'b0; oe_n = 1'b0;
    cyc(hold);
    d  = ebi_data_o;
    oe = ebi_data_oe;
    oe_n = 1'b1; cs_n = 1'b1;
    cyc(4);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  localparam logic [127:0] CR_EXP = 128'h00000000_00000000_00000000_11ADBEEF;
  localparam logic [127:0] TDR_EXP = 128'h00000000_00001234_00000000_00000000;

  initial begin
    logic [31:0] rd;
    logic        oe;

    rst = 1'b1;
    bus_idle();
    ebi_addr   = '0;
    ebi_data_i = '0;
    int_i      = '0;
    sr_i       = {32'hCAFE_0003, 32'h0000_5002, 32'h0000_5001, 32'h0000_5000};
    rdr_i      = {32'h0000_00D3, 32'h0000_00D2, 32'h0000_0055, 32'h0000_00D0};
    cyc(3);
    rst = 1'b0;
    cyc(3);

    // Reset state
    check("reset_cr",    cr_o, '0);
    check("reset_tdr",   tdr_o, '0);
    check("reset_oe",    ebi_data_oe, 1'b0);
    check("reset_data",  ebi_data_o, '0);
    check("reset_state", dbg_state_o, 2'd0);
    check("reset_irq",   irq_o, 1'b0);

    // TDR write, lanes 0/1 only
    snap();
    ebi_write(24'd10, 32'hA5A5_1234, 4'b1100);
    check("tdr_ch2_write", tdr_o, TDR_EXP);
    check("tdr_tx_pulse",  tx_delta(), 16'h0100);

    // CR full write then lane-3-only write
    ebi_write(24'd0, 32'hDEAD_BEEF, 4'b0000);
    ebi_write(24'd0, 32'h1122_3344, 4'b0111);
    check("cr_lane_merge", cr_o, CR_EXP);
    check("cr_no_tx",      tx_delta(), 16'h0100);

    // RDR read with long hold: one rx pulse
    snap();
    ebi_read(24'd7, RD_HOLD, rd, oe);
    check("rdr_ch1_data", rd, 32'h0000_0055);
    check("rdr_ch1_oe",   oe, 1'b1);
    check("rdr_rx_pulse", rx_delta(), 16'h0010);
    check("rdr_no_sr",    sr_delta(), 16'h0000);
    check("oe_released",  ebi_data_oe, 1'b0);

    // SR read
    snap();
    ebi_read(24'd13, RD_HOLD, rd, oe);
    check("sr_ch3_data",  rd, 32'hCAFE_0003);
    check("sr_pulse",     sr_delta(), 16'h1000);
    check("sr_no_rx",     rx_delta(), 16'h0000);

    ebi_read(24'd0, RD_HOLD, rd, oe);
    check("cr_ch0_read", rd, 32'h11AD_BEEF);
    ebi_read(24'd10, RD_HOLD, rd, oe);
    check("tdr_ch2_read", rd, 32'h0000_1234);

    // Interrupt mask and aggregation
    ebi_write(24'd17, 32'h0000_0004, 4'b0000);
    int_i = 4'b0110;
    cyc(1);
    check("irq_set", irq_o, 1'b1);
    ebi_read(24'd16, RD_HOLD, rd, oe);
    check("irq_status", rd, 32'h0000_0006);
    ebi_read(24'd17, RD_HOLD, rd, oe);
    check("irq_mask", rd, 32'h0000_0004);
    int_i = 4'b0010;
    cyc(1);
    check("irq_clear", irq_o, 1'b0);

    // Unmapped channel 7 and read-only registers
    snap();
    ebi_write(24'd28, 32'hFFFF_FFFF, 4'b0000);
    ebi_write(24'd30, 32'hFFFF_FFFF, 4'b0000);
    ebi_write(24'd5,  32'hFFFF_FFFF, 4'b0000);
    ebi_write(24'd7,  32'hFFFF_FFFF, 4'b0000);
    ebi_write(24'd18, 32'hFFFF_FFFF, 4'b0000);
    ebi_read(24'd31, RD_HOLD, rd, oe);
    check("ch7_rdr_read", rd, 32'h0);
    ebi_read(24'd29, RD_HOLD, rd, oe);
    check("ch7_sr_read", rd, 32'h0);
    check("hole_cr",  cr_o, CR_EXP);
    check("hole_tdr", tdr_o, TDR_EXP);
    check("hole_tx",  tx_delta(), 16'h0000);
    check("hole_rx",  rx_delta(), 16'h0000);
    check("hole_sr",  sr_delta(), 16'h0000);
    ebi_read(24'd18, RD_HOLD, rd, oe);
    check("version", rd, 32'h0002_0000);
    ebi_read(24'd17, RD_HOLD, rd, oe);
    check("mask_kept", rd, 32'h0000_0004);
    ebi_read(24'd19, RD_HOLD, rd, oe);
    check("bus_err_idle", rd, 32'h0);

    // Write aborted by cs_n rising before we_n
    @(negedge clk);
    ebi_addr = 24'd12; ebi_data_i = 32'hFFFF_FFFF; rd_wr = 1'b0; cs_n = 1'b0; we_n = 4'h0;
    cyc(6);
    cs_n = 1'b1;
    cyc(4);
    we_n = 4'hF; rd_wr = 1'b1;
    cyc(4);
    check("abort_cr", cr_o, CR_EXP);

`ifdef BUS_TIMEOUT_EN
    // Watchdog: oe present for cycles 4..18 after strobes fall, dropped at 19
    snap();
    @(negedge clk);
    ebi_addr = 24'd7; rd_wr = 1'b1; cs_n = 1'b0; oe_n = 1'b0;
    cyc(18);
    check("to_oe_before", ebi_data_oe, 1'b1);
    cyc(1);
    check("to_oe_dropped", ebi_data_oe, 1'b0);
    check("to_wait_state", dbg_state_o, 2'd3);
    cyc(21);
    check("to_oe_held_low", ebi_data_oe, 1'b0);
    oe_n = 1'b1; cs_n = 1'b1;
    cyc(4);
    check("to_back_idle", dbg_state_o, 2'd0);
    check("to_rx_once", rx_delta(), 16'h0010);
    ebi_read(24'd19, RD_HOLD, rd, oe);
    check("bus_err_set", rd, 32'h1);
    ebi_write(24'd19, 32'h0000_0001, 4'b0000);
    ebi_read(24'd19, RD_HOLD, rd, oe);
    check("bus_err_cleared", rd, 32'h0);
`endif

    // Reset asserted in the middle of a read
    @(negedge clk);
    ebi_addr = 24'd0; rd_wr = 1'b1; cs_n = 1'b0; oe_n = 1'b0;
    cyc(8);
    check("midrd_oe", ebi_data_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_oe_async",  ebi_data_oe, 1'b0);
    check("rst_cr_async",  cr_o, '0);
    check("rst_tdr_async", tdr_o, '0);
    check("rst_state",     dbg_state_o, 2'd0);
    bus_idle();
    cyc(2);
    rst = 1'b0;
    cyc(3);
    ebi_read(24'd17, RD_HOLD, rd, oe);
    check("rst_mask_zero", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
